// File: rtl/atari_pkg.sv
// rtl/atari_pkg.sv - shared constants and write-FSM state for the Atari scanline buffer
package atari_pkg;
   localparam int LINE_PIXELS = 160;
   localparam int COLOR_W     = 7;
   localparam int HPOS_W      = 10;
   localparam int PTR_W       = 8;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } wr_state_t;
endpackage

// File: rtl/line_ram.sv
// rtl/line_ram.sv - simple dual-port line RAM, synchronous read, bank bit as address MSB
module line_ram #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 7
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   // No reset so the array maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/atari_line_buffer.sv
// rtl/atari_line_buffer.sv - double-buffered 160-pixel scanline store feeding the HDMI stage
module atari_line_buffer #(
   parameter int LINE_PIXELS  = atari_pkg::LINE_PIXELS,
   parameter int H_SCALE_LOG2 = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [6:0] wr_color,
   input  logic [9:0] hpos,
   input  logic       in_image,
   input  logic       in_hblank,
   output logic [6:0] color,
   output logic       line_request,
   output logic       underrun
);
   import atari_pkg::*;

   localparam int ADDR_W = PTR_W + 1;

   wr_state_t         state;
   logic [PTR_W-1:0]  wr_ptr;
   logic              rd_bank;
   logic              have_line;
   logic              hblank_q;
   logic              rd_valid_q;
   logic              hblank_rise;
   logic              wr_fire;
   logic [HPOS_W-1:0] idx;
   logic              rd_ok;
   logic [6:0]        ram_q;

   assign hblank_rise = in_hblank && !hblank_q;
   assign wr_ready    = (state == FILL);
   assign wr_fire     = wr_valid && (state == FILL);
   assign idx         = hpos >> H_SCALE_LOG2;
   assign rd_ok       = in_image && have_line && (idx < HPOS_W'(LINE_PIXELS));

   // The display bank is only touched by reads; writes always go to the other bank.
   line_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (COLOR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_fire),
      .wr_addr ({~rd_bank, wr_ptr}),
      .wr_data (wr_color),
      .rd_addr ({rd_bank, idx[PTR_W-1:0]}),
      .rd_data (ram_q)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= FILL;
         wr_ptr       <= '0;
         rd_bank      <= 1'b0;
         have_line    <= 1'b0;
         hblank_q     <= 1'b0;
         rd_valid_q   <= 1'b0;
         line_request <= 1'b0;
         underrun     <= 1'b0;
      end else begin
         hblank_q     <= in_hblank;
         rd_valid_q   <= rd_ok;
         line_request <= 1'b0;
         underrun     <= 1'b0;
         if (hblank_rise && state == FULL) begin
            rd_bank      <= ~rd_bank;
            have_line    <= 1'b1;
            wr_ptr       <= '0;
            state        <= FILL;
            line_request <= 1'b1;
         end else begin
            // An edge judged against FILL is an underrun even if this cycle's write completes the line.
            if (hblank_rise)
               underrun <= 1'b1;
            if (wr_fire) begin
               if (wr_ptr == PTR_W'(LINE_PIXELS - 1))
                  state <= FULL;
               else
                  wr_ptr <= wr_ptr + 1'b1;
            end
         end
      end
   end

   assign color = rd_valid_q ? ram_q : '0;
endmodule

// File: tb/tb_atari_line_buffer.sv
// tb/tb_atari_line_buffer.sv - directed self-checking bench for atari_line_buffer
module tb_atari_line_buffer;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [6:0] wr_color = '0;
   logic [9:0] hpos = '0;
   logic       in_image = 1'b0;
   logic       in_hblank = 1'b0;
   logic [6:0] color;
   logic       line_request;
   logic       underrun;

   int checks = 0;
   int errors = 0;

   atari_line_buffer dut (
      .clk          (clk),
      .reset        (reset),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_color     (wr_color),
      .hpos         (hpos),
      .in_image     (in_image),
      .in_hblank    (in_hblank),
      .color        (color),
      .line_request (line_request),
      .underrun     (underrun)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Writes pixels first..first+n-1 with value (index*mul + add) & 0x7F.
   task automatic write_pixels(input int first, input int n, input int mul, input int add);
      for (int i = first; i < first + n; i++) begin
         wr_valid = 1'b1;
         wr_color = 7'((i * mul + add) & 127);
         tick();
      end
      wr_valid = 1'b0;
   endtask

   task automatic show(input int h, input logic img);
      hpos = 10'(h);
      in_image = img;
      tick();
   endtask

   task automatic test_reset();
      #3;
      checks++; if (color !== 7'd0) begin errors++; $display("FAIL reset_color got %0d want 0", color); end
      checks++; if (line_request !== 1'b0) begin errors++; $display("FAIL reset_line_request got %b want 0", line_request); end
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", underrun); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      logic [6:0] e;
      write_pixels(0, 160, 1, 0);
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL basic_full_ready got %b want 0", wr_ready); end
      in_hblank = 1'b1;
      tick();
      checks++; if (line_request !== 1'b1) begin errors++; $display("FAIL basic_line_request got %b want 1", line_request); end
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL basic_underrun got %b want 0", underrun); end
      in_hblank = 1'b0;
      tick();
      checks++; if (line_request !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got %b want 0", line_request); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after_swap got %b want 1", wr_ready); end
      for (int h = 0; h < 640; h++) begin
         show(h, 1'b1);
         e = 7'((h >> 2) & 127);
         checks++; if (color !== e) begin errors++; $display("FAIL basic_hpos_%0d got %0d want %0d", h, color, e); end
      end
   endtask

   task automatic test_blank();
      show(10, 1'b0);
      checks++; if (color !== 7'd0) begin errors++; $display("FAIL blank_in_image0 got %0d want 0", color); end
      show(640, 1'b1);
      checks++; if (color !== 7'd0) begin errors++; $display("FAIL blank_hpos640 got %0d want 0", color); end
      show(1023, 1'b1);
      checks++; if (color !== 7'd0) begin errors++; $display("FAIL blank_hpos1023 got %0d want 0", color); end
      show(639, 1'b1);
      checks++; if (color !== 7'd31) begin errors++; $display("FAIL blank_hpos639 got %0d want 31", color); end
   endtask

   task automatic test_async_reset();
      write_pixels(0, 160, 2, 3);
      show(400, 1'b1);
      checks++; if (color !== 7'd100) begin errors++; $display("FAIL areset_before_color got %0d want 100", color); end
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL areset_before_ready got %b want 0", wr_ready); end
      #2 reset = 1'b1;
      #1;
      checks++; if (color !== 7'd0) begin errors++; $display("FAIL areset_color got %0d want 0", color); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL areset_wr_ready got %b want 1", wr_ready); end
      tick();
      reset = 1'b0;
      show(400, 1'b1);
      checks++; if (color !== 7'd0) begin errors++; $display("FAIL areset_no_line got %0d want 0", color); end
   endtask

   task automatic test_underrun();
      write_pixels(0, 100, 3, 1);
      in_hblank = 1'b1;
      tick();
      checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_pulse got %b want 1", underrun); end
      checks++; if (line_request !== 1'b0) begin errors++; $display("FAIL underrun_no_request got %b want 0", line_request); end
      in_hblank = 1'b0;
      tick();
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_pulse_width got %b want 0", underrun); end
      show(0, 1'b1);
      checks++; if (color !== 7'd0) begin errors++; $display("FAIL underrun_display0 got %0d want 0", color); end
      show(400, 1'b1);
      checks++; if (color !== 7'd0) begin errors++; $display("FAIL underrun_display400 got %0d want 0", color); end
      write_pixels(100, 60, 3, 1);
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL underrun_full got %b want 0", wr_ready); end
      in_hblank = 1'b1;
      tick();
      checks++; if (line_request !== 1'b1) begin errors++; $display("FAIL underrun_swap got %b want 1", line_request); end
      in_hblank = 1'b0;
      show(400, 1'b1);
      checks++; if (color !== 7'd45) begin errors++; $display("FAIL underrun_hpos400 got %0d want 45", color); end
      show(0, 1'b1);
      checks++; if (color !== 7'd1) begin errors++; $display("FAIL underrun_hpos0 got %0d want 1", color); end
      show(639, 1'b1);
      checks++; if (color !== 7'd94) begin errors++; $display("FAIL underrun_hpos639 got %0d want 94", color); end
   endtask

   task automatic test_backpressure();
      int acc = 0;
      for (int c = 0; c < 200; c++) begin
         wr_valid = 1'b1;
         wr_color = 7'(acc & 127);
         if (wr_ready) acc++;
         tick();
      end
      checks++; if (acc !== 160) begin errors++; $display("FAIL backpressure_accepts got %0d want 160", acc); end
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL backpressure_ready got %b want 0", wr_ready); end
      wr_valid = 1'b0;
      in_hblank = 1'b1;
      tick();
      checks++; if (line_request !== 1'b1) begin errors++; $display("FAIL backpressure_swap got %b want 1", line_request); end
      in_hblank = 1'b0;
      show(520, 1'b1);
      checks++; if (color !== 7'd2) begin errors++; $display("FAIL backpressure_hpos520 got %0d want 2", color); end
      show(636, 1'b1);
      checks++; if (color !== 7'd31) begin errors++; $display("FAIL backpressure_hpos636 got %0d want 31", color); end
   endtask

   task automatic test_simultaneous();
      write_pixels(0, 159, 1, 7);
      wr_valid = 1'b1;
      wr_color = 7'd38;
      in_hblank = 1'b1;
      tick();
      checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL simul_underrun got %b want 1", underrun); end
      checks++; if (line_request !== 1'b0) begin errors++; $display("FAIL simul_no_request got %b want 0", line_request); end
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL simul_full got %b want 0", wr_ready); end
      wr_valid = 1'b0;
      in_hblank = 1'b0;
      show(520, 1'b1);
      checks++; if (color !== 7'd2) begin errors++; $display("FAIL simul_old_line got %0d want 2", color); end
      in_hblank = 1'b1;
      tick();
      checks++; if (line_request !== 1'b1) begin errors++; $display("FAIL simul_swap got %b want 1", line_request); end
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL simul_swap_underrun got %b want 0", underrun); end
      in_hblank = 1'b0;
      show(0, 1'b1);
      checks++; if (color !== 7'd7) begin errors++; $display("FAIL simul_hpos0 got %0d want 7", color); end
      show(636, 1'b1);
      checks++; if (color !== 7'd38) begin errors++; $display("FAIL simul_hpos636 got %0d want 38", color); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_blank();
      test_async_reset();
      test_underrun();
      test_backpressure();
      test_simultaneous();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
